axi4_lite_arbiter: RTL and testbench
====================================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 SHALL have no parameters; address and data are 32 bits, wstrb 4 bits, resp 2 bits, matching axi4_lite_interface.
REQ-002 SHALL have: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have: m0  axi4_lite_interface.slave  bundle  requester 0 (IFU); fields awvalid/awready/awaddr, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr, rvalid/rready/rresp/rdata.
REQ-005 SHALL have: m1  axi4_lite_interface.slave  bundle  requester 1 (LSU); same fields.
REQ-006 SHALL have: s  axi4_lite_interface.master  bundle  shared downstream slave; same fields.
REQ-007 SHALL have: busy  output  1  high while any transaction is granted.
REQ-008 SHALL have: owner  output  1  index of granted requester; 0 when idle.

Function
REQ-009 SHALL implement states IDLE, M0_RD, M0_WR, M1_RD, M1_WR in one registered state variable.
REQ-010 In IDLE SHALL drive all s.*valid, s.bready, s.rready low and all m0/m1 readies and valids low.
REQ-011 Request from mX = mX.arvalid | mX.awvalid, sampled in IDLE only.
REQ-012 Single requester in IDLE: SHALL grant it at next clock edge (1-cycle arbitration latency).
REQ-013 Both requesting in IDLE: SHALL grant requester other than last_grant (round-robin); last_grant resets to 1 so m0 wins first contention.
REQ-014 Granted master asserting both arvalid and awvalid: SHALL enter RD state (read before write).
REQ-015 In Mx_RD SHALL connect AR and R channels of mX to s combinationally, drive s.awvalid, s.wvalid, s.bready low and mX.awready, mX.wready, mX.bvalid low.
REQ-016 In Mx_WR SHALL connect AW, W and B channels of mX to s combinationally, drive s.arvalid, s.rready low and mX.arready, mX.rvalid low.
REQ-017 Non-granted master SHALL see all readies and response valids low for the whole grant; its valids and payloads are not forwarded.
REQ-018 Mx_RD SHALL return to IDLE on the cycle after s.rvalid & s.rready; Mx_WR on the cycle after s.bvalid & s.bready.
REQ-019 On leaving any grant state SHALL set last_grant to that state's requester index.
REQ-020 AW and W handshakes within Mx_WR SHALL complete in any order, either same cycle; arbiter does not reorder or buffer them.
REQ-021 Response fields (rdata, rresp, bresp) SHALL pass through unmodified, including SLVERR/DECERR.
REQ-022 Minimum spacing between consecutive grants SHALL be one IDLE cycle; no transaction is dropped while requester holds valid.
REQ-023 busy SHALL be high exactly in the four grant states; owner SHALL equal granted index in grant states.
REQ-024 One outstanding transaction total; SHALL not grant while a response is pending.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, last_grant 1, busy 0, owner 0, and all outputs per REQ-010.
REQ-026 Reset mid-transaction SHALL abandon it silently; no response is delivered after reset release.
REQ-027 First grant after rst_n rises SHALL occur no earlier than the second rising edge with rst_n high.

Verification
REQ-028 m0 arvalid araddr=0x8000_0000, slave rdata=0x0000_0413 one cycle later -> m0 sees arready, rvalid with rdata 0x0000_0413; busy high 2+ cycles; back to IDLE.
REQ-029 m0 and m1 arvalid same cycle after reset -> m0 granted first, m1 granted after m0 R handshake plus one IDLE cycle; next contention grants m1 first.
REQ-030 m1 write awaddr=0xa000_03f8, wdata=0x41, wstrb=0x1, slave B delayed 5 cycles, m0 arvalid meanwhile -> m0 arready stays 0 until m1 B handshake; then m0 served.
REQ-031 m0 asserts arvalid and awvalid together -> read performed first, s.awvalid stays 0; write granted in subsequent arbitration.
REQ-032 rst_n pulled low while in M1_WR with W pending -> all outputs go to IDLE values immediately without clock; after release a new m0 read completes normally.
REQ-033 Slave returns rresp=2'b10 -> m1 receives rresp 2'b10 unchanged and arbiter returns to IDLE.

Source files
------------

// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite signal bundle shared by the requesters and the downstream slave.
// 32-bit address/data, 4-bit write strobe, 2-bit response.
interface axi4_lite_interface;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-requester AXI4-Lite arbiter (m0 = IFU, m1 = LSU) onto one shared slave.
// One transaction in flight; round-robin on contention; reads win over writes.
module axi4_lite_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    axi4_lite_interface.slave  m0,
    axi4_lite_interface.slave  m1,
    axi4_lite_interface.master s,
    output logic               busy,
    output logic               owner
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] M0_RD = 3'd1;
    localparam logic [2:0] M0_WR = 3'd2;
    localparam logic [2:0] M1_RD = 3'd3;
    localparam logic [2:0] M1_WR = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       last_grant;
    logic       last_grant_nxt;
    logic       armed;

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic rd_done;
    logic wr_done;
    logic sel_m1;

    assign req0    = m0.arvalid | m0.awvalid;
    assign req1    = m1.arvalid | m1.awvalid;
    assign grant0  = req0 & (~req1 | last_grant);
    assign grant1  = req1 & (~req0 | ~last_grant);
    assign rd_done = s.rvalid & s.rready;
    assign wr_done = s.bvalid & s.bready;

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            armed      <= 1'b1;
        end
    end

    // armed holds off arbitration for the first edge after reset release.
    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (armed) begin
                    if (grant0)      state_nxt = m0.arvalid ? M0_RD : M0_WR;
                    else if (grant1) state_nxt = m1.arvalid ? M1_RD : M1_WR;
                end
            end
            M0_RD: if (rd_done) begin state_nxt = IDLE; last_grant_nxt = 1'b0; end
            M0_WR: if (wr_done) begin state_nxt = IDLE; last_grant_nxt = 1'b0; end
            M1_RD: if (rd_done) begin state_nxt = IDLE; last_grant_nxt = 1'b1; end
            M1_WR: if (wr_done) begin state_nxt = IDLE; last_grant_nxt = 1'b1; end
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_m1 = (state == M1_RD) || (state == M1_WR);
    assign busy   = (state != IDLE);
    assign owner  = sel_m1;

    // Request payloads follow the selected requester; handshakes gate their use.
    assign s.araddr = sel_m1 ? m1.araddr : m0.araddr;
    assign s.awaddr = sel_m1 ? m1.awaddr : m0.awaddr;
    assign s.wdata  = sel_m1 ? m1.wdata  : m0.wdata;
    assign s.wstrb  = sel_m1 ? m1.wstrb  : m0.wstrb;

    // Response payloads pass through untouched; only the valids are steered.
    assign m0.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m0.bresp = s.bresp;
    assign m1.rdata = s.rdata;
    assign m1.rresp = s.rresp;
    assign m1.bresp = s.bresp;

    always_comb begin
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        s.awvalid  = 1'b0;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bvalid  = 1'b0;
        case (state)
            M0_RD: begin
                s.arvalid  = m0.arvalid;
                s.rready   = m0.rready;
                m0.arready = s.arready;
                m0.rvalid  = s.rvalid;
            end
            M0_WR: begin
                s.awvalid  = m0.awvalid;
                s.wvalid   = m0.wvalid;
                s.bready   = m0.bready;
                m0.awready = s.awready;
                m0.wready  = s.wready;
                m0.bvalid  = s.bvalid;
            end
            M1_RD: begin
                s.arvalid  = m1.arvalid;
                s.rready   = m1.rready;
                m1.arready = s.arready;
                m1.rvalid  = s.rvalid;
            end
            M1_WR: begin
                s.awvalid  = m1.awvalid;
                s.wvalid   = m1.wvalid;
                s.bready   = m1.bready;
                m1.awready = s.awready;
                m1.wready  = s.wready;
                m1.bvalid  = s.bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: two bus-functional requesters, a
// simple responding slave, grant-order log and a leakage monitor.
module tb_axi4_lite_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic owner;

    axi4_lite_interface m0_if ();
    axi4_lite_interface m1_if ();
    axi4_lite_interface s_if ();

    axi4_lite_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave model configuration and captured write payload
    logic [31:0] slv_rdata = 32'h0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;
    int          b_delay = 0;
    logic [31:0] slv_awaddr;
    logic [31:0] slv_wdata;
    logic [3:0]  slv_wstrb;
    logic        aw_got;
    logic        w_got;
    int          bcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_if.rvalid <= 1'b0;
            s_if.rdata  <= 32'h0;
            s_if.rresp  <= 2'b00;
        end else if (s_if.rvalid && s_if.rready) begin
            s_if.rvalid <= 1'b0;
        end else if (s_if.arvalid && s_if.arready) begin
            s_if.rvalid <= 1'b1;
            s_if.rdata  <= slv_rdata;
            s_if.rresp  <= slv_rresp;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_if.bvalid <= 1'b0;
            s_if.bresp  <= 2'b00;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            bcnt        <= 0;
        end else begin
            if (s_if.awvalid && s_if.awready) begin
                aw_got     <= 1'b1;
                slv_awaddr <= s_if.awaddr;
            end
            if (s_if.wvalid && s_if.wready) begin
                w_got     <= 1'b1;
                slv_wdata <= s_if.wdata;
                slv_wstrb <= s_if.wstrb;
            end
            if (s_if.bvalid && s_if.bready) begin
                s_if.bvalid <= 1'b0;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
                bcnt        <= 0;
            end else if (aw_got && w_got && !s_if.bvalid) begin
                if (bcnt >= b_delay) begin
                    s_if.bvalid <= 1'b1;
                    s_if.bresp  <= slv_bresp;
                end else begin
                    bcnt <= bcnt + 1;
                end
            end
        end
    end

    // Grant log entries are {owner, s.awvalid} at the first cycle of each grant.
    logic       prev_busy;
    int         idle_cnt;
    int         leak = 0;
    int         aw_in_rd = 0;
    logic [1:0] grant_log[$];
    int         gap_log[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
            idle_cnt  <= 0;
        end else begin
            prev_busy <= busy;
            idle_cnt  <= busy ? 0 : idle_cnt + 1;
            if (busy && !prev_busy) begin
                grant_log.push_back({owner, s_if.awvalid});
                gap_log.push_back(idle_cnt);
            end
            if (!(busy && owner == 1'b0) &&
                (m0_if.arready | m0_if.awready | m0_if.wready | m0_if.rvalid | m0_if.bvalid))
                leak <= leak + 1;
            if (!(busy && owner == 1'b1) &&
                (m1_if.arready | m1_if.awready | m1_if.wready | m1_if.rvalid | m1_if.bvalid))
                leak <= leak + 1;
            if (s_if.arvalid && s_if.awvalid)
                aw_in_rd <= aw_in_rd + 1;
        end
    end

    function automatic void set_ar(input bit idx, input logic v, input logic [31:0] a);
        if (idx) begin m1_if.arvalid = v; m1_if.araddr = a; end
        else     begin m0_if.arvalid = v; m0_if.araddr = a; end
    endfunction

    function automatic void set_rready(input bit idx, input logic v);
        if (idx) m1_if.rready = v; else m0_if.rready = v;
    endfunction

    function automatic void set_aw(input bit idx, input logic v, input logic [31:0] a);
        if (idx) begin m1_if.awvalid = v; m1_if.awaddr = a; end
        else     begin m0_if.awvalid = v; m0_if.awaddr = a; end
    endfunction

    function automatic void set_w(input bit idx, input logic v, input logic [31:0] d, input logic [3:0] st);
        if (idx) begin m1_if.wvalid = v; m1_if.wdata = d; m1_if.wstrb = st; end
        else     begin m0_if.wvalid = v; m0_if.wdata = d; m0_if.wstrb = st; end
    endfunction

    function automatic void set_bready(input bit idx, input logic v);
        if (idx) m1_if.bready = v; else m0_if.bready = v;
    endfunction

    task automatic do_read(input bit idx, input logic [31:0] addr,
                           output logic [31:0] data, output logic [1:0] resp, output bit to);
        bit ar_done = 1'b0;
        bit r_done = 1'b0;
        bit ar_hs;
        data = 32'hx;
        resp = 2'bx;
        set_ar(idx, 1'b1, addr);
        set_rready(idx, 1'b1);
        for (int n = 0; n < 100 && !r_done; n++) begin
            @(negedge clk);
            ar_hs = !ar_done && (idx ? m1_if.arready : m0_if.arready);
            if (ar_done && (idx ? m1_if.rvalid : m0_if.rvalid)) begin
                data   = idx ? m1_if.rdata : m0_if.rdata;
                resp   = idx ? m1_if.rresp : m0_if.rresp;
                r_done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ar_hs) begin
                ar_done = 1'b1;
                set_ar(idx, 1'b0, 32'h0);
            end
        end
        set_ar(idx, 1'b0, 32'h0);
        set_rready(idx, 1'b0);
        to = !r_done;
    endtask

    task automatic do_write(input bit idx, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output bit to);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit b_done = 1'b0;
        bit aw_hs;
        bit w_hs;
        resp = 2'bx;
        set_aw(idx, 1'b1, addr);
        set_w(idx, 1'b1, data, strb);
        set_bready(idx, 1'b1);
        for (int n = 0; n < 100 && !b_done; n++) begin
            @(negedge clk);
            aw_hs = !aw_done && (idx ? m1_if.awready : m0_if.awready);
            w_hs  = !w_done && (idx ? m1_if.wready : m0_if.wready);
            if (aw_done && w_done && (idx ? m1_if.bvalid : m0_if.bvalid)) begin
                resp   = idx ? m1_if.bresp : m0_if.bresp;
                b_done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (aw_hs) begin aw_done = 1'b1; set_aw(idx, 1'b0, 32'h0); end
            if (w_hs)  begin w_done = 1'b1;  set_w(idx, 1'b0, 32'h0, 4'h0); end
        end
        set_aw(idx, 1'b0, 32'h0);
        set_w(idx, 1'b0, 32'h0, 4'h0);
        set_bready(idx, 1'b0);
        to = !b_done;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        grant_log.delete();
        gap_log.delete();
        @(negedge clk);
    endtask

    logic [31:0] d0a, d0b, d1, d2;
    logic [1:0]  r0a, r0b, r1, r2, br;
    bit          to0a, to0b, to1, to2, tow;
    bit          got;

    initial begin
        set_ar(0, 1'b0, 32'h0); set_ar(1, 1'b0, 32'h0);
        set_aw(0, 1'b0, 32'h0); set_aw(1, 1'b0, 32'h0);
        set_w(0, 1'b0, 32'h0, 4'h0); set_w(1, 1'b0, 32'h0, 4'h0);
        set_rready(0, 1'b0); set_rready(1, 1'b0);
        set_bready(0, 1'b0); set_bready(1, 1'b0);
        s_if.arready = 1'b1;
        s_if.awready = 1'b1;
        s_if.wready  = 1'b1;

        // Reset values with a request already pending, then release timing
        set_ar(0, 1'b1, 32'h8000_0000);
        slv_rdata = 32'h0000_0413;
        #12;
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_s_arvalid", s_if.arvalid, 0);
        check("rst_m0_arready", m0_if.arready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_edge1_busy", busy, 0);
        @(negedge clk);
        check("rel_edge2_busy", busy, 1);
        check("rel_owner", owner, 0);
        check("rd0_s_araddr", s_if.araddr, 32'h8000_0000);
        check("rd0_m0_arready", m0_if.arready, 1);
        @(posedge clk);
        #1;
        set_ar(0, 1'b0, 32'h0);
        set_rready(0, 1'b1);
        @(negedge clk);
        check("rd0_m0_rvalid", m0_if.rvalid, 1);
        check("rd0_rdata", m0_if.rdata, 32'h0000_0413);
        check("rd0_busy_cycle2", busy, 1);
        @(posedge clk);
        #1;
        set_rready(0, 1'b0);
        @(negedge clk);
        check("rd0_idle_after", busy, 0);

        // Contention after reset: m0 first, then m1 beats m0's re-request
        apply_reset();
        slv_rdata = 32'h0000_0011;
        fork
            begin
                do_read(0, 32'h1000, d0a, r0a, to0a);
                do_read(0, 32'h1004, d0b, r0b, to0b);
            end
            do_read(1, 32'h2000, d1, r1, to1);
        join
        check("rr_timeouts", {29'h0, to0a, to0b, to1}, 0);
        check("rr_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            check("rr_first_m0", grant_log[0], 2'b00);
            check("rr_second_m1", grant_log[1], 2'b10);
            check("rr_third_m0", grant_log[2], 2'b00);
            check("rr_idle_gap", gap_log[1], 1);
        end
        check("rr_m1_rdata", d1, 32'h0000_0011);
        check("rr_m0_rdata", d0b, 32'h0000_0011);

        // m1 write with slow B; m0 read must wait for it
        grant_log.delete();
        b_delay = 5;
        slv_bresp = 2'b00;
        slv_rdata = 32'h0000_0022;
        fork
            do_write(1, 32'ha000_03f8, 32'h0000_0041, 4'h1, br, tow);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_read(0, 32'h3000, d2, r2, to2);
            end
            begin
                repeat (4) @(negedge clk);
                check("wr_hold_m0_arready", m0_if.arready, 0);
                check("wr_hold_owner", owner, 1);
            end
        join
        check("wr_timeouts", {30'h0, tow, to2}, 0);
        check("wr_awaddr", slv_awaddr, 32'ha000_03f8);
        check("wr_wdata", slv_wdata, 32'h0000_0041);
        check("wr_wstrb", slv_wstrb, 4'h1);
        check("wr_bresp", br, 2'b00);
        check("wr_m0_rdata", d2, 32'h0000_0022);
        check("wr_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("wr_first_m1_write", grant_log[0], 2'b11);
            check("wr_then_m0_read", grant_log[1], 2'b00);
        end

        // m0 read and write together: read first, write later, DECERR passes
        grant_log.delete();
        b_delay = 1;
        slv_bresp = 2'b11;
        slv_rdata = 32'h0000_0055;
        fork
            do_read(0, 32'h4000, d0a, r0a, to0a);
            do_write(0, 32'h4008, 32'h0000_cafe, 4'hf, br, tow);
        join
        check("rw_timeouts", {30'h0, to0a, tow}, 0);
        check("rw_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("rw_read_first", grant_log[0], 2'b00);
            check("rw_write_second", grant_log[1], 2'b01);
        end
        check("rw_no_aw_in_read", aw_in_rd, 0);
        check("rw_rdata", d0a, 32'h0000_0055);
        check("rw_bresp_decerr", br, 2'b11);
        check("rw_awaddr", slv_awaddr, 32'h4008);

        // Reset in the middle of an m1 write with W still pending
        set_aw(1, 1'b1, 32'h5000);
        set_bready(1, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy && owner) got = 1'b1;
        end
        check("mid_rst_grant_seen", got, 1);
        @(posedge clk);
        #1;
        set_aw(1, 1'b0, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_owner", owner, 0);
        check("mid_rst_s_awvalid", s_if.awvalid, 0);
        check("mid_rst_s_bready", s_if.bready, 0);
        check("mid_rst_m1_wready", m1_if.wready, 0);
        set_bready(1, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_m1_bvalid", m1_if.bvalid, 0);
        check("post_rst_busy", busy, 0);
        slv_rdata = 32'h0000_0077;
        do_read(0, 32'h6000, d0a, r0a, to0a);
        check("post_rst_read_to", to0a, 0);
        check("post_rst_rdata", d0a, 32'h0000_0077);

        // SLVERR on read reaches m1 unchanged
        slv_rresp = 2'b10;
        slv_rdata = 32'hdead_beef;
        do_read(1, 32'h7000, d1, r1, to1);
        check("slverr_to", to1, 0);
        check("slverr_rresp", r1, 2'b10);
        check("slverr_rdata", d1, 32'hdead_beef);
        @(negedge clk);
        check("slverr_idle", busy, 0);

        check("no_leak", leak, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
